// File: rtl/qsn_controller_pipe_if.sv
// Purpose : handshake/bus bundle between the layer scheduler, the QSN
//           controller and the QSN datapath.
// Modports:
//   master - scheduler/datapath side: drives in_valid, shift_factor,
//            perm_len, out_ready; observes in_ready and the select outputs
//   slave  - controller side: the mirror image of master
interface qsn_controller_pipe_if #(
    parameter int MAX_LEN = 15,
    parameter int SHIFT_W = $clog2(MAX_LEN + 1),
    parameter int MERGE_W = MAX_LEN - 1
);
    logic               in_valid;
    logic               in_ready;
    logic [SHIFT_W-1:0] shift_factor;
    logic [SHIFT_W-1:0] perm_len;
    logic               out_valid;
    logic               out_ready;
    logic [SHIFT_W-1:0] left_sel;
    logic [SHIFT_W-1:0] right_sel;
    logic [MERGE_W-1:0] merge_sel;
    logic               err;

    modport master (
        output in_valid, shift_factor, perm_len, out_ready,
        input  in_ready, out_valid, left_sel, right_sel, merge_sel, err
    );

    modport slave (
        input  in_valid, shift_factor, perm_len, out_ready,
        output in_ready, out_valid, left_sel, right_sel, merge_sel, err
    );
endinterface

// File: rtl/qsn_controller_pipe.sv
// Purpose : two-stage pipelined controller for a cyclic-shift (QSN) network.
//           Converts {shift, permutation length L} into left/right barrel
//           shifter selects and a merge mask, for any L in 2..MAX_LEN.
// Ports   :
//   i_sys_clk - single clock, rising edge
//   i_rstn    - asynchronous active-low reset
//   bus       - qsn_controller_pipe_if.slave: in_valid/in_ready/shift_factor/
//               perm_len from the scheduler, out_valid/out_ready/left_sel/
//               right_sel/merge_sel/err toward the datapath
// Config  : QSN_MOD_REDUCE_EN - when defined, shifts >= L are reduced modulo L
//           by a subtract-once-per-cycle FSM in stage 1; when undefined such
//           shifts are flagged with err and the FSM never leaves IDLE.
//
// S1 FSM states:
//   state    | meaning
//   S_IDLE   | S1 empty or holding a reduced shift ready for S2
//   S_REDUCE | S1 subtracting L from the shift; not offered to S2
module qsn_controller_pipe #(
    parameter int MAX_LEN = 15,
    parameter int SHIFT_W = $clog2(MAX_LEN + 1),
    parameter int MERGE_W = MAX_LEN - 1
) (
    input logic                 i_sys_clk,
    input logic                 i_rstn,
    qsn_controller_pipe_if.slave bus
);
    localparam int                 LEN_W     = SHIFT_W + 1;
    localparam logic [LEN_W-1:0]   LEN_MIN   = LEN_W'(2);
    localparam logic [LEN_W-1:0]   LEN_MAX   = LEN_W'(MAX_LEN);
    localparam logic [MERGE_W-1:0] MERGE_ONE = MERGE_W'(1);

    typedef enum logic {S_IDLE, S_REDUCE} state_t;

    state_t             r_state;
    logic               r_s1_valid;
    logic [SHIFT_W-1:0] r_s1_s;
    logic [SHIFT_W-1:0] r_s1_len;
    logic               r_s1_err;

    logic               r_s2_valid;
    logic [SHIFT_W-1:0] r_left;
    logic [SHIFT_W-1:0] r_right;
    logic [MERGE_W-1:0] r_merge;
    logic               r_err;

    logic               w_s1_fwd;
    logic               w_s2_load;
    logic               w_s1_load;
    logic               w_in_ready;
    logic               w_accept;
    logic [LEN_W-1:0]   w_len_ext;
    logic               w_len_ok;
    logic               w_wrap;
    logic [SHIFT_W-1:0] w_dec_right;
    logic [MERGE_W-1:0] w_merge_mask;

    assign w_s1_fwd   = r_s1_valid && (r_state == S_IDLE);
    assign w_s2_load  = !r_s2_valid || bus.out_ready;
    assign w_s1_load  = !r_s1_valid || (w_s1_fwd && w_s2_load);
    assign w_in_ready = w_s1_load && (r_state == S_IDLE);
    assign w_accept   = bus.in_valid && w_in_ready;

    assign w_len_ext  = {1'b0, bus.perm_len};
    assign w_len_ok   = (w_len_ext >= LEN_MIN) && (w_len_ext <= LEN_MAX);
    assign w_wrap     = bus.shift_factor >= bus.perm_len;

    // right = L-s is at most MAX_LEN-1 == MERGE_W; shifting a MERGE_W-wide one
    // by MERGE_W gives 0, and 0-1 wraps to the all-ones mask, which is the
    // correct (1<<(L-s))-1 truncated to the mask width.
    assign w_dec_right  = r_s1_len - r_s1_s;
    assign w_merge_mask = (MERGE_ONE << w_dec_right) - MERGE_ONE;

`ifdef QSN_MOD_REDUCE_EN
    logic [SHIFT_W-1:0] w_s_sub;
    assign w_s_sub = r_s1_s - r_s1_len;
`endif

    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= S_IDLE;
            r_s1_valid <= 1'b0;
            r_s1_s     <= '0;
            r_s1_len   <= '0;
            r_s1_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_s     <= bus.shift_factor;
                r_s1_len   <= bus.perm_len;
`ifdef QSN_MOD_REDUCE_EN
                r_s1_err   <= !w_len_ok;
                if (w_len_ok && w_wrap) begin
                    r_state <= S_REDUCE;
                end
`else
                r_s1_err   <= !w_len_ok || w_wrap;
`endif
            end else if (w_s1_fwd && w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
`ifdef QSN_MOD_REDUCE_EN
            // No accept can coincide with REDUCE because in_ready is low.
            if (r_state == S_REDUCE) begin
                r_s1_s <= w_s_sub;
                if (w_s_sub < r_s1_len) begin
                    r_state <= S_IDLE;
                end
            end
`endif
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_s2_valid <= 1'b0;
            r_left     <= '0;
            r_right    <= '0;
            r_merge    <= '0;
            r_err      <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= w_s1_fwd;
            if (w_s1_fwd) begin
                if (r_s1_err || (r_s1_s == '0)) begin
                    r_left  <= '0;
                    r_right <= '0;
                    r_merge <= '0;
                end else begin
                    r_left  <= r_s1_s;
                    r_right <= w_dec_right;
                    r_merge <= w_merge_mask;
                end
                r_err <= r_s1_err;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.left_sel  = r_left;
    assign bus.right_sel = r_right;
    assign bus.merge_sel = r_merge;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_qsn_controller_pipe.sv
module tb_qsn_controller_pipe;
    logic clk;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   tog    = 0;

    typedef struct {
        logic [3:0]  left;
        logic [3:0]  right;
        logic [13:0] merge;
        logic        err;
        int          acc;
        int          lat;
        bit          lat_chk;
    } exp_t;

    exp_t q[$];

    qsn_controller_pipe_if bus ();

    qsn_controller_pipe dut (
        .i_sys_clk(clk),
        .i_rstn   (rstn),
        .bus      (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int s_in, input int len, input int acc, input bit lat_chk);
        exp_t e;
        int   s;
        s         = s_in;
        e.left    = '0;
        e.right   = '0;
        e.merge   = '0;
        e.err     = 1'b0;
        e.acc     = acc;
        e.lat     = 2;
        e.lat_chk = lat_chk;
        if (len < 2 || len > 15) begin
            e.err = 1'b1;
        end else begin
            if (s >= len) begin
`ifdef QSN_MOD_REDUCE_EN
                e.lat = 2 + s / len;
                s     = s % len;
`else
                e.err = 1'b1;
`endif
            end
            if (!e.err && s != 0) begin
                e.left  = 4'(s);
                e.right = 4'(len - s);
                e.merge = 14'((1 << (len - s)) - 1);
            end
        end
        return e;
    endfunction

    task automatic apply_ready();
        if (tog) bus.out_ready = ~bus.out_ready;
        else     bus.out_ready = 1'b1;
    endtask

    task automatic send(input int s, input int len, input bit lat_chk);
        int budget;
        budget = 0;
        @(negedge clk); #1;
        bus.in_valid     = 1'b1;
        bus.shift_factor = 4'(s);
        bus.perm_len     = 4'(len);
        apply_ready();
        #2;
        while (!bus.in_ready) begin
            budget++;
            if (budget > 50) begin
                chk("in_ready_timeout", {31'b0, bus.in_ready}, 32'd1);
                break;
            end
            @(negedge clk); #1;
            apply_ready();
            #2;
        end
        if (bus.in_ready) q.push_back(model(s, len, cyc, lat_chk));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            bus.in_valid = 1'b0;
            apply_ready();
        end
    endtask

    // Scoreboard and stall-hold monitor, sampled just before each rising edge.
    bit          hold = 0;
    logic [3:0]  h_left, h_right;
    logic [13:0] h_merge;
    logic        h_err;

    always begin
        exp_t e;
        @(negedge clk); #3;
        if (!rstn) begin
            hold = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
                chk("hold_left",  {28'b0, bus.left_sel},  {28'b0, h_left});
                chk("hold_right", {28'b0, bus.right_sel}, {28'b0, h_right});
                chk("hold_merge", {18'b0, bus.merge_sel}, {18'b0, h_merge});
                chk("hold_err",   {31'b0, bus.err},       {31'b0, h_err});
            end
            if (bus.out_valid && bus.out_ready) begin
                hold = 0;
                if (q.size() == 0) begin
                    chk("spurious_out", {31'b0, bus.out_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("left",  {28'b0, bus.left_sel},  {28'b0, e.left});
                    chk("right", {28'b0, bus.right_sel}, {28'b0, e.right});
                    chk("merge", {18'b0, bus.merge_sel}, {18'b0, e.merge});
                    chk("err",   {31'b0, bus.err},       {31'b0, e.err});
                    if (e.lat_chk) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end else if (bus.out_valid) begin
                hold    = 1;
                h_left  = bus.left_sel;
                h_right = bus.right_sel;
                h_merge = bus.merge_sel;
                h_err   = bus.err;
            end else begin
                hold = 0;
            end
        end
    end

    initial begin
        int budget;
        rstn             = 1'b0;
        bus.in_valid     = 1'b0;
        bus.shift_factor = '0;
        bus.perm_len     = '0;
        bus.out_ready    = 1'b1;

        @(negedge clk); #3;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_left",      {28'b0, bus.left_sel},  32'd0);
        chk("rst_right",     {28'b0, bus.right_sel}, 32'd0);
        chk("rst_merge",     {18'b0, bus.merge_sel}, 32'd0);
        chk("rst_err",       {31'b0, bus.err},       32'd0);
        @(negedge clk); #1;
        rstn = 1'b1;
        #2;
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        send(0, 15, 1);  idle(4);
        send(1, 15, 1);  idle(4);
        send(3, 7, 1);   idle(4);

        tog = 1;
        for (int s = 1; s <= 14; s++) send(s, 15, 0);
        tog = 0;
        idle(8);

        send(9, 7, 1);
        @(negedge clk); #3;
`ifdef QSN_MOD_REDUCE_EN
        chk("reduce_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
`else
        chk("reduce_in_ready_low", {31'b0, bus.in_ready}, 32'd1);
`endif
        @(negedge clk); #3;
        chk("reduce_in_ready_back", {31'b0, bus.in_ready}, 32'd1);
        idle(5);

        send(14, 7, 1);  idle(6);
        send(15, 15, 1); idle(5);
        send(6, 2, 1);   idle(7);
        send(1, 1, 1);   idle(4);
        send(5, 0, 0);
        send(2, 9, 0);
        send(7, 3, 0);
        idle(8);

        send(2, 15, 0);
        send(4, 15, 0);
        #1;
        rstn = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_left",      {28'b0, bus.left_sel},  32'd0);
        chk("midrst_merge",     {18'b0, bus.merge_sel}, 32'd0);
        q.delete();
        @(negedge clk); #1;
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk); #3;
            chk("post_rst_no_output", {31'b0, bus.out_valid}, 32'd0);
        end

        send(3, 7, 1);
        budget = 0;
        while (q.size() != 0 && budget < 100) begin
            idle(1);
            budget++;
        end
        idle(2);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
